// File: rtl/reduce_accum.sv
// Streaming signed reduction (saturating sum / max / min) over a run of len elements.
// A single FSM gates the input handshake and holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for start; op/len latched and accumulator seeded on start
// ACCUM | accepting elements until remaining reaches zero
// DONE  | result presented on out_data/out_sat until out_ready
module reduce_accum #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [CNT_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_sat,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                    state, state_nxt;
    logic [1:0]                op_q;
    logic [CNT_W-1:0]          remaining;
    logic signed [WIDTH-1:0]   acc;
    logic                      sat;

    logic signed [WIDTH:0]     sum_ext;
    logic signed [WIDTH-1:0]   acc_upd;
    logic                      sat_upd;
    logic signed [WIDTH-1:0]   identity;
    logic                      handshake;

    assign handshake = (state == ACCUM) && in_valid;

    // Sign-extended sum: overflow shows up as the top two bits disagreeing.
    assign sum_ext = {acc[WIDTH-1], acc} + {in_data[WIDTH-1], in_data};

    always_comb begin
        acc_upd = acc;
        sat_upd = 1'b0;
        case (op_q)
            2'b01: begin
                if (in_data > acc) acc_upd = in_data;
            end
            2'b10: begin
                if (in_data < acc) acc_upd = in_data;
            end
            default: begin
                if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
                    sat_upd = 1'b1;
                    acc_upd = sum_ext[WIDTH] ? MIN_NEG : MAX_POS;
                end else begin
                    acc_upd = sum_ext[WIDTH-1:0];
                end
            end
        endcase
    end

    always_comb begin
        case (op)
            2'b01:   identity = MIN_NEG;
            2'b10:   identity = MAX_POS;
            default: identity = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (in_valid && remaining == CNT_ONE) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= 2'b00;
            remaining <= '0;
            acc       <= '0;
            sat       <= 1'b0;
        end else if (state == IDLE && start) begin
            op_q      <= op;
            remaining <= len;
            acc       <= identity;
            sat       <= 1'b0;
        end else if (handshake) begin
            acc       <= acc_upd;
            sat       <= sat | sat_upd;
            remaining <= remaining - CNT_ONE;
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? acc : '0;
    assign out_sat   = (state == DONE) ? sat : 1'b0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_reduce_accum.sv
// Directed bench for reduce_accum: sum, saturation, max/min, empty run, backpressure,
// abort by reset and ignored start, each against hand-computed results.
module tb_reduce_accum;

    logic               clk;
    logic               rst;
    logic               start;
    logic [1:0]         op;
    logic [7:0]         len;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               out_sat;
    logic               busy;

    int checks;
    int failures;

    reduce_accum #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; start is seen by the next rising edge.
    task automatic start_red(input logic [1:0] o, input logic [7:0] n);
        start = 1'b1;
        op    = o;
        len   = n;
        @(negedge clk);
        start = 1'b0;
        op    = 2'b11;
        len   = 8'd77;
    endtask

    task automatic feed(input logic [15:0] d);
        check("in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'h5A5A;
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_release", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {16'd0, out_data},  32'd0);
        check("rst_out_sat",   {31'd0, out_sat},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        // rst wins over a simultaneous start
        start = 1'b1;
        len   = 8'd3;
        @(negedge clk);
        check("rst_over_start", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Sum 1+2+3-4 = 2 with out_ready held high
        out_ready = 1'b1;
        start_red(2'b00, 8'd4);
        check("sum_busy", {31'd0, busy}, 32'd1);
        feed(16'd1);
        feed(16'd2);
        feed(16'd3);
        check("sum_not_done", {31'd0, out_valid}, 32'd0);
        feed(16'hFFFC);
        check("sum_valid", {31'd0, out_valid}, 32'd1);
        check("sum_data",  {16'd0, out_data},  32'h0002);
        check("sum_sat",   {31'd0, out_sat},   32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        check("sum_idle", {31'd0, busy}, 32'd0);

        // 0x7000+0x7000 clamps to 0x7FFF, then -1 gives 0x7FFE
        start_red(2'b00, 8'd3);
        feed(16'h7000);
        feed(16'h7000);
        feed(16'hFFFF);
        check("sat_valid", {31'd0, out_valid}, 32'd1);
        check("sat_data",  {16'd0, out_data},  32'h7FFE);
        check("sat_flag",  {31'd0, out_sat},   32'd1);
        release_result();

        start_red(2'b01, 8'd4);
        feed(16'hFFFB);
        feed(16'd7);
        feed(16'd7);
        feed(16'h8000);
        check("max_data", {16'd0, out_data}, 32'h0007);
        check("max_sat",  {31'd0, out_sat},  32'd0);
        release_result();

        // min with stall gaps between elements
        start_red(2'b10, 8'd4);
        feed(16'hFFFB);
        repeat (2) @(negedge clk);
        check("min_gap_stall", {31'd0, in_ready}, 32'd1);
        feed(16'd7);
        @(negedge clk);
        feed(16'd7);
        repeat (3) @(negedge clk);
        check("min_gap_no_done", {31'd0, out_valid}, 32'd0);
        feed(16'h8000);
        check("min_data", {16'd0, out_data}, 32'h8000);
        release_result();

        // Empty min reduction under backpressure
        start_red(2'b10, 8'd0);
        check("empty_valid", {31'd0, out_valid}, 32'd1);
        check("empty_data",  {16'd0, out_data},  32'h7FFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data",  {16'd0, out_data},  32'h7FFF);
        end
        release_result();
        check("bp_out_valid_low", {31'd0, out_valid}, 32'd0);

        // Back-to-back start in the IDLE cycle right after release
        start_red(2'b01, 8'd0);
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_data",  {16'd0, out_data},  32'h8000);
        // start raised in the DONE cycle is ignored
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd0;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("done_start_ignored", {31'd0, busy}, 32'd0);

        // Abort after 2 of 4 elements
        start_red(2'b00, 8'd4);
        feed(16'd100);
        feed(16'd200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        start_red(2'b00, 8'd1);
        feed(16'd9);
        check("abort_valid", {31'd0, out_valid}, 32'd1);
        check("abort_data",  {16'd0, out_data},  32'h0009);
        check("abort_sat",   {31'd0, out_sat},   32'd0);
        release_result();

        // start with len=2 during ACCUM must not reload the run
        start_red(2'b00, 8'd4);
        feed(16'd5);
        start = 1'b1;
        len   = 8'd2;
        op    = 2'b01;
        @(negedge clk);
        start = 1'b0;
        feed(16'd6);
        feed(16'd7);
        check("ign_not_done", {31'd0, out_valid}, 32'd0);
        feed(16'd8);
        check("ign_valid", {31'd0, out_valid}, 32'd1);
        check("ign_data",  {16'd0, out_data},  32'd26);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reduce_accum.md
REDUCE_ACCUM -- requirements
Module: reduce_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the signed data width of the input and result.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the element-count field.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request a new reduction; sampled only in IDLE.
REQ-006 SHALL have port op, input, 2 bits: 00 saturating signed sum, 01 signed max, 10 signed min, 11 treated as 00.
REQ-007 SHALL have port len, input, CNT_W bits: number of elements to reduce; 0 is legal.
REQ-008 SHALL have port in_valid, input, 1 bit: the upstream element is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts an element.
REQ-010 SHALL have port in_data, input, WIDTH bits: signed element.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream register stage accepts the result.
REQ-013 SHALL have port out_data, output, WIDTH bits: signed reduction result.
REQ-014 SHALL have port out_sat, output, 1 bit: a saturation occurred during this reduction (sum only).
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-017 In IDLE, start=1 SHALL latch op and len, set remaining=len, load acc with the identity value and clear sat.
REQ-018 Identity values SHALL be: sum 0; max -2^(WIDTH-1) (0x8000); min 2^(WIDTH-1)-1 (0x7FFF).
REQ-019 From IDLE, start with len=0 SHALL go to DONE; start with len>0 SHALL go to ACCUM.
REQ-020 in_ready SHALL be 1 only in ACCUM; a handshake occurs when in_valid and in_ready are both 1.
REQ-021 On each handshake, the block SHALL update acc with in_data per the latched op and decrement remaining.
REQ-022 Sum SHALL be computed at WIDTH+1 bits and clamped to [0x8000, 0x7FFF]; any clamp SHALL set sat, which stays set until the next start.
REQ-023 Max and min SHALL use signed comparison; on a tie, acc SHALL be unchanged.
REQ-024 The handshake on the last element (remaining=1) SHALL move the FSM to DONE, so out_valid is asserted on the next cycle (1-cycle latency).
REQ-025 In DONE, out_valid SHALL be 1, out_data SHALL equal acc and out_sat SHALL equal sat.
REQ-026 out_data and out_sat SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 In DONE, out_ready=1 SHALL return the FSM to IDLE on the next cycle; back-to-back start SHALL be accepted in that IDLE cycle.
REQ-028 start SHALL be ignored outside IDLE, including a start raised in the same cycle as the DONE->IDLE transition.
REQ-029 Gaps in in_valid during ACCUM SHALL stall without changing acc or remaining.
REQ-030 op and len changes after start SHALL have no effect on the reduction in progress.

Reset
REQ-031 When rst=1 at a clock edge, state SHALL become IDLE, and acc, remaining and sat SHALL become 0.
REQ-032 While in reset, outputs SHALL be in_ready=0, out_valid=0, out_data=0, out_sat=0 and busy=0.
REQ-033 rst asserted mid-ACCUM or in DONE SHALL abort the reduction and discard the result; no out_valid pulse SHALL follow.
REQ-034 rst SHALL take priority over start and over any handshake in the same cycle.

Verification
REQ-035 Sum test: op=00, len=4, inputs 1, 2, 3, -4 with out_ready=1 SHALL produce out_valid one cycle after the 4th handshake, out_data=2 and out_sat=0.
REQ-036 Saturation test: op=00, len=3, inputs 0x7000, 0x7000, -1 SHALL produce out_data=0x7FFE and out_sat=1.
REQ-037 Max/min test: inputs -5, 7, 7, -32768 SHALL produce 7 with op=01 and -32768 (0x8000) with op=10.
REQ-038 Empty and backpressure test: len=0 with op=10 SHALL produce out_data=0x7FFF in DONE; with out_ready=0 for 5 cycles, out_valid and out_data SHALL stay stable, then return to IDLE one cycle after out_ready=1.
REQ-039 Abort test: assert rst after 2 of 4 elements, then start len=1 with input 9 (op=00); the bench SHALL see out_data=9 with no residual from the aborted reduction.
REQ-040 Ignore test: a start pulse with len=2 issued during ACCUM SHALL not alter remaining; the result SHALL reflect only the original len.
